core_sequencer: RTL

Multi-cycle control FSM for the single-issue core. It sequences instruction fetch, decode, execute, memory and write-back around the instruction decoder, ALU, register file and PC. It consumes the decoder's classification flags (is_load, is_store, is_halt, reg_we) and drives the IR latch, PC update, register-file write strobe and the request/acknowledge handshakes to instruction and data memory.

---
 rtl/core_sequencer.sv | 136 +++++++++++++
 1 files changed

// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/wb control FSM for the single-issue core.
// Optional counters: define PERF_CNT_EN to build cycle_cnt / instret_cnt.
module core_sequencer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             reg_we,
  output logic             imem_req,
  input  logic             imem_ack,
  output logic             ir_we,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic             rf_we,
  output logic             pc_we,
  output logic             retire,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instret_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   w_store;

  // load wins when both flags are set
  assign w_store = is_store & ~is_load;
  assign state   = r_state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    ir_we    = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    pc_we    = 1'b0;
    retire   = 1'b0;
    halted   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          w_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_next = is_halt ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        w_next = (is_load | is_store) ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_store;
        if (dmem_ack) begin
          if (is_load) begin
            w_next = S_WB;
          end else begin
            pc_we  = 1'b1;
            retire = 1'b1;
            w_next = S_FETCH;
          end
        end
      end
      S_WB: begin
        rf_we  = reg_we & ~w_store;
        pc_we  = 1'b1;
        retire = 1'b1;
        w_next = S_FETCH;
      end
      S_HALT: begin
        halted = 1'b1;
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

`ifdef PERF_CNT_EN
  localparam logic [CNT_W-1:0] ONE = 1;

  logic [CNT_W-1:0] r_cyc;
  logic [CNT_W-1:0] r_ret;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (r_state != S_IDLE && r_state != S_HALT) begin
        r_cyc <= r_cyc + ONE;
      end
      if (retire) begin
        r_ret <= r_ret + ONE;
      end
    end
  end

  assign cycle_cnt   = r_cyc;
  assign instret_cnt = r_ret;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule
